// File: rtl/i2c_master.sv
`timescale 1ns/1ps
// Single-byte I2C master: register write or register read (repeated START, one byte, NACK) per request.
// Latency: START is on the bus the clock after Req is accepted; each bus slot is 4*CNT_Q clocks; Done is a one-clock pulse.
// Backpressure: Req is only sampled while Busy=0; a request made while busy is dropped, never queued.
// Ports: Clk/Rst_n; request side Req, Rw, Dev_addr, Reg_addr, Wr_data; status Busy, Done, Ack_err, Rd_vld, Rd_data;
//        pad side Sclk (push-pull), Sda_in, Sda_oe, Sda_o (tri-state split, wired-AND bus with external pull-up).
module i2c_master #(
    parameter int SYS_FREQ = 50_000_000,
    parameter int SCL_FREQ = 100_000
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       Req,
    input  logic       Rw,
    input  logic [6:0] Dev_addr,
    input  logic [7:0] Reg_addr,
    input  logic [7:0] Wr_data,
    output logic       Busy,
    output logic       Done,
    output logic       Ack_err,
    output logic       Rd_vld,
    output logic [7:0] Rd_data,
    output logic       Sclk,
    input  logic       Sda_in,
    output logic       Sda_oe,
    output logic       Sda_o
);

    // Quarter-bit length in system clocks; must be at least 2.
    localparam int CNT_Q = SYS_FREQ / (4 * SCL_FREQ);
    localparam int CW    = $clog2(CNT_Q);
    localparam logic [CW-1:0] CNT_LAST = CW'(CNT_Q - 1);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_START   = 4'd1;
    localparam logic [3:0] S_TX_BYTE = 4'd2;
    localparam logic [3:0] S_RX_ACK  = 4'd3;
    localparam logic [3:0] S_RESTART = 4'd4;
    localparam logic [3:0] S_RX_BYTE = 4'd5;
    localparam logic [3:0] S_TX_NACK = 4'd6;
    localparam logic [3:0] S_STOP    = 4'd7;
    localparam logic [3:0] S_FINISH  = 4'd8;

    logic [3:0]    state;
    logic [CW-1:0] cnt;
    logic [1:0]    phase;
    logic [2:0]    bit_cnt;
    logic [1:0]    byte_idx;   // 0: address+W, 1: register, 2: data (write) or address+R (read)
    logic          rw_q;
    logic [6:0]    dev_q;
    logic [7:0]    reg_q;
    logic [7:0]    wdat_q;
    logic [7:0]    tx_sh;
    logic [7:0]    rx_sh;

    logic q_end;
    logic slot_end;
    logic sample;

    assign q_end    = (cnt == CNT_LAST);
    assign slot_end = q_end && (phase == 2'd3);
    // SCL has been high for a full quarter by now, so the slave's data is settled.
    assign sample   = (phase == 2'd3) && (cnt == '0);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            phase    <= 2'd0;
            bit_cnt  <= 3'd0;
            byte_idx <= 2'd0;
            rw_q     <= 1'b0;
            dev_q    <= 7'd0;
            reg_q    <= 8'd0;
            wdat_q   <= 8'd0;
            tx_sh    <= 8'd0;
            rx_sh    <= 8'd0;
            Ack_err  <= 1'b0;
            Rd_data  <= 8'h00;
        end else begin
            // Slot timing only runs while a bus slot is in progress.
            if (state == S_IDLE || state == S_FINISH) begin
                cnt   <= '0;
                phase <= 2'd0;
            end else if (q_end) begin
                cnt   <= '0;
                phase <= phase + 2'd1;
            end else begin
                cnt <= cnt + CW'(1);
            end

            if (sample) begin
                if (state == S_RX_ACK && Sda_in) Ack_err <= 1'b1;
                if (state == S_RX_BYTE) rx_sh <= {rx_sh[6:0], Sda_in};
            end

            case (state)
                S_IDLE: begin
                    if (Req) begin
                        rw_q    <= Rw;
                        dev_q   <= Dev_addr;
                        reg_q   <= Reg_addr;
                        wdat_q  <= Wr_data;
                        Ack_err <= 1'b0;
                        state   <= S_START;
                    end
                end
                S_START: begin
                    if (slot_end) begin
                        tx_sh    <= {dev_q, 1'b0};
                        bit_cnt  <= 3'd0;
                        byte_idx <= 2'd0;
                        state    <= S_TX_BYTE;
                    end
                end
                S_TX_BYTE: begin
                    if (slot_end) begin
                        tx_sh   <= {tx_sh[6:0], 1'b0};
                        bit_cnt <= bit_cnt + 3'd1;   // wraps to 0 for the next byte
                        if (bit_cnt == 3'd7) state <= S_RX_ACK;
                    end
                end
                S_RX_ACK: begin
                    // Ack_err was set at the sample point earlier in this slot.
                    if (slot_end) begin
                        if (Ack_err) begin
                            state <= S_STOP;
                        end else begin
                            case (byte_idx)
                                2'd0: begin
                                    tx_sh    <= reg_q;
                                    byte_idx <= 2'd1;
                                    state    <= S_TX_BYTE;
                                end
                                2'd1: begin
                                    if (rw_q) begin
                                        state <= S_RESTART;
                                    end else begin
                                        tx_sh    <= wdat_q;
                                        byte_idx <= 2'd2;
                                        state    <= S_TX_BYTE;
                                    end
                                end
                                default: state <= rw_q ? S_RX_BYTE : S_STOP;
                            endcase
                        end
                    end
                end
                S_RESTART: begin
                    if (slot_end) begin
                        tx_sh    <= {dev_q, 1'b1};
                        byte_idx <= 2'd2;
                        state    <= S_TX_BYTE;
                    end
                end
                S_RX_BYTE: begin
                    if (slot_end) begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= S_TX_NACK;
                    end
                end
                S_TX_NACK: begin
                    if (slot_end) state <= S_STOP;
                end
                S_STOP: begin
                    if (slot_end) begin
                        // Load here so Rd_data is already valid while Rd_vld pulses.
                        if (rw_q && !Ack_err) Rd_data <= rx_sh;
                        state <= S_FINISH;
                    end
                end
                S_FINISH: state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

    // Pad drive is a pure decode of registered state, so reset releases the bus immediately.
    always_comb begin
        Sclk   = 1'b1;
        Sda_oe = 1'b0;
        Sda_o  = 1'b1;
        case (state)
            S_START: begin
                Sda_oe = 1'b1;
                Sda_o  = ~phase[1];
            end
            S_TX_BYTE: begin
                Sclk   = phase[1];
                Sda_oe = 1'b1;
                Sda_o  = tx_sh[7];
            end
            S_RX_ACK, S_RX_BYTE: begin
                Sclk = phase[1];
            end
            S_TX_NACK: begin
                Sclk   = phase[1];
                Sda_oe = 1'b1;
            end
            S_RESTART: begin
                Sclk   = (phase != 2'd0);
                Sda_oe = 1'b1;
                Sda_o  = ~phase[1];
            end
            S_STOP: begin
                Sclk   = (phase != 2'd0);
                Sda_oe = ~phase[1];
                Sda_o  = 1'b0;
            end
            default: begin
                Sclk   = 1'b1;
                Sda_oe = 1'b0;
                Sda_o  = 1'b1;
            end
        endcase
    end

    assign Busy   = (state != S_IDLE);
    assign Done   = (state == S_FINISH);
    assign Rd_vld = (state == S_FINISH) && rw_q && !Ack_err;

endmodule

// File: tb/tb_i2c_master.sv
`timescale 1ns/1ps
// Directed bench for i2c_master with a behavioural slave on a wired-AND SDA line.
// Bus runs at CNT_Q = 20 (8 MHz / (4*100 kHz)), so one slot is 80 clocks.
// Slave logs received bytes, ACKs or NACKs a chosen byte, returns a fixed read byte, counts START/STOP edges.
module tb_i2c_master;

    localparam int SLOT = 80;
    localparam int T_WR = 29 * SLOT + 1;   // START + 27 bits + STOP
    localparam int T_RD = 39 * SLOT + 1;   // START + 27 bits + RESTART + 9 + NACK... + STOP
    localparam int T_NA = 11 * SLOT + 1;   // START + 9 + STOP
    localparam int T_NR = 20 * SLOT + 1;   // START + 18 + STOP

    logic       Clk = 1'b0;
    logic       Rst_n;
    logic       Req;
    logic       Rw;
    logic [6:0] Dev_addr;
    logic [7:0] Reg_addr;
    logic [7:0] Wr_data;
    logic       Busy, Done, Ack_err, Rd_vld;
    logic [7:0] Rd_data;
    logic       Sclk, Sda_in, Sda_oe, Sda_o;

    always #5 Clk = ~Clk;

    i2c_master #(.SYS_FREQ(8_000_000), .SCL_FREQ(100_000)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Req(Req), .Rw(Rw), .Dev_addr(Dev_addr),
        .Reg_addr(Reg_addr), .Wr_data(Wr_data), .Busy(Busy), .Done(Done),
        .Ack_err(Ack_err), .Rd_vld(Rd_vld), .Rd_data(Rd_data), .Sclk(Sclk),
        .Sda_in(Sda_in), .Sda_oe(Sda_oe), .Sda_o(Sda_o)
    );

    // ---------------- behavioural slave ----------------
    logic       s_drv = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] s_tx_byte = 8'h00;
    int         nack_at = -1;
    logic [7:0] s_log [0:7];
    int         s_nbytes = 0, n_start = 0, n_stop = 0, n_rdvld = 0;
    int         s_bit = 0;
    logic       s_tx = 1'b0, s_first = 1'b0, s_mack = 1'b0;
    logic [7:0] s_sh = 8'h00;
    logic       prev_scl = 1'b1, prev_sda = 1'b1;

    assign Sda_in = ~((Sda_oe & ~Sda_o) | s_drv);

    always @(negedge Clk) begin
        logic scl, sda;
        scl = Sclk;
        sda = Sda_in;
        if (clr) begin
            s_nbytes = 0; n_start = 0; n_stop = 0; n_rdvld = 0;
        end
        if (!Rst_n || clr) begin
            s_bit = 0; s_tx = 1'b0; s_drv = 1'b0; s_first = 1'b0; s_mack = 1'b0;
        end else begin
            if (Rd_vld) n_rdvld++;
            if (prev_scl && scl && prev_sda && !sda) begin
                n_start++;
                s_bit = 0; s_tx = 1'b0; s_drv = 1'b0; s_first = 1'b1;
            end else if (prev_scl && scl && !prev_sda && sda) begin
                n_stop++;
                s_drv = 1'b0;
            end else if (!prev_scl && scl) begin
                if (s_bit < 8) begin
                    if (!s_tx) s_sh = {s_sh[6:0], sda};
                end else if (s_tx) begin
                    s_mack = sda;
                end
                s_bit++;
            end else if (prev_scl && !scl) begin
                if (s_bit == 8) begin
                    if (!s_tx) begin
                        if (s_nbytes < 8) s_log[s_nbytes] = s_sh;
                        s_drv = (s_nbytes != nack_at);
                        s_nbytes++;
                    end else begin
                        s_drv = 1'b0;
                    end
                end else begin
                    if (s_bit == 9) begin
                        s_bit = 0;
                        if (s_first && s_sh[0]) s_tx = 1'b1;
                        else if (s_tx && s_mack) s_tx = 1'b0;
                        s_first = 1'b0;
                    end
                    s_drv = s_tx && (s_bit < 8) && !s_tx_byte[7 - s_bit];
                end
            end
        end
        prev_scl = scl;
        prev_sda = ~((Sda_oe & ~Sda_o) | s_drv);
    end

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;
    logic       d_ack, d_vld;
    logic [7:0] d_data;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drives a one-cycle request; returns right after the accepting edge.
    task automatic start_txn(input logic rw, input logic [6:0] dev, input logic [7:0] ra,
                             input logic [7:0] wd);
        @(posedge Clk);
        #1;
        clr = 1'b1;
        Req = 1'b1; Rw = rw; Dev_addr = dev; Reg_addr = ra; Wr_data = wd;
        @(posedge Clk);
        #1;
        Req = 1'b0;
        clr = 1'b0;
        chk("busy_after_req", 32'(Busy), 32'd1);
        chk("ack_err_cleared", 32'(Ack_err), 32'd0);
    endtask

    // n0 = edges already elapsed, counting the accepting edge as 1.
    task automatic wait_done(input string tag, input int n0, input int exp_cyc);
        int n;
        logic got;
        n = n0;
        got = 1'b0;
        while (n < exp_cyc + 200 && !got) begin
            @(posedge Clk);
            #1;
            n++;
            if (Done) got = 1'b1;
        end
        chk({tag, "_done_cycle"}, got ? 32'(n) : 32'd0, 32'(exp_cyc));
        d_ack  = Ack_err;
        d_vld  = Rd_vld;
        d_data = Rd_data;
        @(posedge Clk);
        #1;
        chk({tag, "_done_pulse"}, 32'(Done), 32'd0);
        chk({tag, "_busy_clear"}, 32'(Busy), 32'd0);
    endtask

    initial begin
        Rst_n = 1'b0; Req = 1'b0; Rw = 1'b0;
        Dev_addr = 7'h00; Reg_addr = 8'h00; Wr_data = 8'h00;

        // Reset values
        #12;
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_ack_err", 32'(Ack_err), 32'd0);
        chk("rst_rd_vld", 32'(Rd_vld), 32'd0);
        chk("rst_rd_data", 32'(Rd_data), 32'h00);
        chk("rst_sclk", 32'(Sclk), 32'd1);
        chk("rst_sda_oe", 32'(Sda_oe), 32'd0);
        chk("rst_sda_o", 32'(Sda_o), 32'd1);
        @(posedge Clk);
        #1 Rst_n = 1'b1;
        repeat (3) @(posedge Clk);

        // Write 50/12/A5, slave ACKs all
        nack_at = -1;
        start_txn(1'b0, 7'h50, 8'h12, 8'hA5);
        wait_done("wr", 1, T_WR);
        chk("wr_ack_err", 32'(d_ack), 32'd0);
        chk("wr_rd_vld", 32'(d_vld), 32'd0);
        chk("wr_nbytes", 32'(s_nbytes), 32'd3);
        chk("wr_byte0", 32'(s_log[0]), 32'hA0);
        chk("wr_byte1", 32'(s_log[1]), 32'h12);
        chk("wr_byte2", 32'(s_log[2]), 32'hA5);
        chk("wr_starts", 32'(n_start), 32'd1);
        chk("wr_stops", 32'(n_stop), 32'd1);
        chk("wr_rdvld_count", 32'(n_rdvld), 32'd0);

        // Read 50/34, slave returns 3C
        s_tx_byte = 8'h3C;
        start_txn(1'b1, 7'h50, 8'h34, 8'h00);
        wait_done("rd", 1, T_RD);
        chk("rd_ack_err", 32'(d_ack), 32'd0);
        chk("rd_rd_vld", 32'(d_vld), 32'd1);
        chk("rd_data_at_done", 32'(d_data), 32'h3C);
        chk("rd_nbytes", 32'(s_nbytes), 32'd3);
        chk("rd_byte0", 32'(s_log[0]), 32'hA0);
        chk("rd_byte1", 32'(s_log[1]), 32'h34);
        chk("rd_byte2", 32'(s_log[2]), 32'hA1);
        chk("rd_starts", 32'(n_start), 32'd2);
        chk("rd_stops", 32'(n_stop), 32'd1);
        chk("rd_master_nack", 32'(s_mack), 32'd1);
        repeat (5) @(posedge Clk);
        #1;
        chk("rd_data_held", 32'(Rd_data), 32'h3C);
        chk("rd_vld_once", 32'(n_rdvld), 32'd1);

        // Slave NACKs the address byte
        nack_at = 0;
        s_tx_byte = 8'h99;
        start_txn(1'b1, 7'h22, 8'h01, 8'h00);
        wait_done("na", 1, T_NA);
        chk("na_ack_err", 32'(d_ack), 32'd1);
        chk("na_rd_vld", 32'(d_vld), 32'd0);
        chk("na_nbytes", 32'(s_nbytes), 32'd1);
        chk("na_byte0", 32'(s_log[0]), 32'h44);
        chk("na_starts", 32'(n_start), 32'd1);
        chk("na_stops", 32'(n_stop), 32'd1);
        repeat (4) @(posedge Clk);
        #1;
        chk("na_ack_err_held", 32'(Ack_err), 32'd1);
        chk("na_rd_data_kept", 32'(Rd_data), 32'h3C);

        // Slave NACKs the register byte on a read: no repeated START
        nack_at = 1;
        start_txn(1'b1, 7'h50, 8'h56, 8'h00);
        wait_done("nr", 1, T_NR);
        chk("nr_ack_err", 32'(d_ack), 32'd1);
        chk("nr_rd_vld", 32'(d_vld), 32'd0);
        chk("nr_nbytes", 32'(s_nbytes), 32'd2);
        chk("nr_starts", 32'(n_start), 32'd1);
        chk("nr_stops", 32'(n_stop), 32'd1);
        chk("nr_rdvld_count", 32'(n_rdvld), 32'd0);
        chk("nr_rd_data_kept", 32'(Rd_data), 32'h3C);

        // Req while busy and changing inputs after acceptance
        nack_at = -1;
        start_txn(1'b0, 7'h3A, 8'h07, 8'h5C);
        repeat (100) @(posedge Clk);
        #1;
        Req = 1'b1; Rw = 1'b1; Dev_addr = 7'h11; Reg_addr = 8'hFF; Wr_data = 8'h00;
        @(posedge Clk);
        #1 Req = 1'b0;
        wait_done("bz", 102, T_WR);
        chk("bz_ack_err", 32'(d_ack), 32'd0);
        chk("bz_nbytes", 32'(s_nbytes), 32'd3);
        chk("bz_byte0", 32'(s_log[0]), 32'h74);
        chk("bz_byte1", 32'(s_log[1]), 32'h07);
        chk("bz_byte2", 32'(s_log[2]), 32'h5C);
        chk("bz_starts", 32'(n_start), 32'd1);
        chk("bz_rdvld_count", 32'(n_rdvld), 32'd0);

        // Asynchronous reset in the first data bit (SCL low)
        start_txn(1'b0, 7'h50, 8'h99, 8'h99);
        repeat (84) @(posedge Clk);
        #1;
        chk("pre_rst_sclk", 32'(Sclk), 32'd0);
        Rst_n = 1'b0;
        #1;
        chk("arst_sclk", 32'(Sclk), 32'd1);
        chk("arst_sda_oe", 32'(Sda_oe), 32'd0);
        chk("arst_busy", 32'(Busy), 32'd0);
        @(posedge Clk);
        @(posedge Clk);
        #1 Rst_n = 1'b1;
        repeat (2) @(posedge Clk);

        start_txn(1'b0, 7'h50, 8'hC3, 8'h18);
        wait_done("ar", 1, T_WR);
        chk("ar_ack_err", 32'(d_ack), 32'd0);
        chk("ar_nbytes", 32'(s_nbytes), 32'd3);
        chk("ar_byte0", 32'(s_log[0]), 32'hA0);
        chk("ar_byte1", 32'(s_log[1]), 32'hC3);
        chk("ar_byte2", 32'(s_log[2]), 32'h18);
        chk("ar_starts", 32'(n_start), 32'd1);
        chk("ar_stops", 32'(n_stop), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_master.md
# i2c_master

Single-byte I2C bus master: the initiator end of the board's I2C link, driving Sclk and Sdat toward the existing slave path. A one-cycle request performs either a register write (START, device address + W, register address, data, STOP) or a register read (START, device address + W, register address, repeated START, device address + R, one data byte, NACK, STOP). The block sits beside the system logic and connects to the pad through the same Sda_oe / Sda_o / Sda_in tri-state split used elsewhere on the bus.

## Interface
- SYS_FREQ, 50_000_000, system clock frequency in Hz
- SCL_FREQ, 100_000, bus clock frequency in Hz; quarter-bit count CNT_Q = SYS_FREQ/(4*SCL_FREQ) = 125 at defaults; CNT_Q must be ≥ 2
- Clk  in  1  system clock, 50 MHz
- Rst_n  in  1  reset; asynchronous, active-low
- Req  in  1  start a transaction; sampled only while Busy=0
- Rw  in  1  0 = write, 1 = read; captured with Req
- Dev_addr  in  7  7-bit slave address; captured with Req
- Reg_addr  in  8  register address; captured with Req
- Wr_data  in  8  write byte; captured with Req
- Busy  out  1  transaction in progress
- Done  out  1  one-cycle pulse at end of every transaction
- Ack_err  out  1  valid with Done: 1 = a slave ACK was missing
- Rd_vld  out  1  one-cycle pulse with Done on a successful read
- Rd_data  out  8  last byte read; held until the next successful read
- Sclk  out  1  bus clock, push-pull
- Sda_in  in  1  SDA sampled from pad
- Sda_oe  out  1  1 = master drives SDA
- Sda_o  out  1  SDA drive value when Sda_oe=1

## Operation
- Reset values: Busy=0, Done=0, Ack_err=0, Rd_vld=0, Rd_data=8'h00, Sclk=1, Sda_oe=0, Sda_o=1, state IDLE, counters 0.
- Timing uses a quarter-phase counter (0..CNT_Q-1) and a phase index Q0..Q3; one bus slot = 4*CNT_Q clocks.
- States: IDLE, START, TX_BYTE, RX_ACK, RESTART, RX_BYTE, TX_NACK, STOP, FINISH.
- IDLE: Sclk=1, Sda_oe=0. On Req=1, latch inputs, set Busy, and go to START.
- START slot: Q0–Q1 Sclk=1, SDA=1; Q2–Q3 Sclk=1, SDA=0.
- Data bit slot (TX_BYTE, RX_BYTE, RX_ACK, TX_NACK):
  - Q0–Q1 Sclk=0; Q2–Q3 Sclk=1.
  - SDA changes only at Q0 entry.
  - Sampling of Sda_in happens on the first clock of Q3.
- TX_BYTE: 8 slots, MSB first, Sda_oe=1, then RX_ACK.
- Byte order:
  - Write: {Dev_addr,0}, Reg_addr, Wr_data.
  - Read: {Dev_addr,0}, Reg_addr, RESTART, {Dev_addr,1}, RX_BYTE, TX_NACK.
- RX_ACK: one slot, Sda_oe=0. A sampled 1 sets Ack_err and goes to STOP; a sampled 0 continues.
- RESTART slot: Q0 Sclk=0, SDA=1; Q1 Sclk=1, SDA=1; Q2–Q3 Sclk=1, SDA=0.
- RX_BYTE: 8 slots, Sda_oe=0, shifts the sampled bits in MSB first.
- TX_NACK: one slot, Sda_oe=1, Sda_o=1.
- STOP slot: Q0 Sclk=0, SDA=0; Q1 Sclk=1, SDA=0; Q2–Q3 Sclk=1, Sda_oe=0 (bus released high).
- FINISH: one clock.
  - Pulse Done.
  - Pulse Rd_vld and load Rd_data only if the transaction was a read and Ack_err=0.
  - Clear Busy, return to IDLE.
- Ack_err stays at its value until the next Req is accepted; acceptance clears it.
- Req while Busy=1 is ignored and not queued. Input changes after acceptance have no effect.
- A slave driving SDA during a master TX bit is not detected (no arbitration, no clock stretching).

## Timing
- Req high at clock edge k in IDLE: Busy=1 and START Q0 from edge k+1.
- Write: 29 slots (START + 27 bits + STOP) = 14500 clocks at defaults. Done at edge k+1+14500.
- Read: 39 slots = 19500 clocks. Done at edge k+1+19500.
- NACK on the first address byte: START + 9 + STOP = 11 slots = 5500 clocks, then Done with Ack_err=1.
- Req is accepted the clock after FINISH at the earliest; back-to-back transactions are separated by ≥1 IDLE clock.
- Asynchronous reset mid-transaction immediately forces the reset values. No STOP is generated, and Sclk and SDA float or return high.

## Test plan
- Write, defaults, behavioural slave ACKs everything; Dev 7'h50, Reg 8'h12, Data 8'hA5 → bytes on bus 8'hA0, 8'h12, 8'hA5, STOP; Done at +14501 clocks; Ack_err=0; Rd_vld never pulses.
- Read, Dev 7'h50, Reg 8'h34, slave returns 8'h3C → bus 8'hA0, 8'h34, repeated START, 8'hA1, master NACK, STOP; Rd_vld=Done=1 same cycle; Rd_data=8'h3C and held after.
- Slave NACKs the address byte → STOP right after the 9th bit; Done after 5500 clocks; Ack_err=1; Rd_data unchanged.
- Slave NACKs Reg_addr on a read → no repeated START; Ack_err=1; Rd_vld=0.
- Req pulsed again while Busy, and inputs changed mid-transaction → no effect; bus bytes match the originally captured values.
- Rst_n low midway through TX_BYTE → same-cycle Sclk=1, Sda_oe=0, Busy=0. After release, a new write completes normally.
- Protocol checker on all runs: SDA never changes while Sclk=1, except START, RESTART, and STOP edges.
